// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam word_t PC_STEP    = 32'd4;
    localparam word_t R15_OFFSET = 32'd8;

    function automatic word_t align_word(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry FIFO of fetched {pc, instr} pairs with flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage is cleared on reset so the head reads as zero before any fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem fetch, decode queue and redirect; FETCH_BOUND_EN adds the memory bound stop
module fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC  = 32'h0000_0000,
    parameter int    DEPTH     = 2,
    parameter int    MEM_WORDS = 101
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus8,
    output logic        out_of_range
);

    word_t        pc;
    logic         push;
    logic         pop;
    logic         stop;
    logic         bound_hit;
    logic         q_full;
    logic         q_empty;
    fetch_entry_t q_head;
    fetch_entry_t q_wdata;

    assign imem_addr = pc;
    assign bound_hit = ({2'b00, pc[31:2]} >= 32'(MEM_WORDS));

`ifdef FETCH_BOUND_EN
    logic oor_q;

    assign stop = bound_hit;

    // pc only moves by push or redirect, so stop persists until a redirect lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_q <= 1'b0;
        end else begin
            oor_q <= stop & ~redirect_valid;
        end
    end

    assign out_of_range = oor_q;
`else
    logic unused_bound;

    assign unused_bound = bound_hit;
    assign stop         = 1'b0;
    assign out_of_range = 1'b0;
`endif

    assign dec_valid = ~q_empty;
    assign pop       = dec_valid & dec_ready;
    assign push      = ~redirect_valid & (~q_full | pop) & ~stop;

    assign q_wdata.pc    = pc;
    assign q_wdata.instr = imem_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= align_word(RESET_PC);
        end else if (redirect_valid) begin
            pc <= align_word(redirect_pc);
        end else if (push) begin
            pc <= pc + PC_STEP;
        end
    end

    // A pop in the redirect cycle still retires; flush only drops what remains.
    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (q_wdata),
        .full  (q_full),
        .empty (q_empty),
        .head  (q_head)
    );

    assign dec_instr    = q_head.instr;
    assign dec_pc       = q_head.pc;
    assign dec_pc_plus8 = q_head.pc + R15_OFFSET;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] BASE = 32'hE3A0_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus8;
    logic        out_of_range;

    int tests_run;
    int tests_failed;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (2),
        .MEM_WORDS (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc_plus8   (dec_pc_plus8),
        .out_of_range   (out_of_range)
    );

    assign imem_rd = BASE + imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = rdy;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        tests_run++;
        if (dec_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid got %b want 0", dec_valid);
        end
        tests_run++;
        if (imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_pc got %h want 00000000", imem_addr);
        end
        tests_run++;
        if ({dec_pc, dec_instr} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_head got pc=%h instr=%h want 0/0", dec_pc, dec_instr);
        end
        tests_run++;
        if (out_of_range !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_oor got %b want 0", out_of_range);
        end
    endtask

    task automatic test_stream();
        logic [127:0] exp;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            exp = {32'd1, 32'(4 * i), BASE + 32'(4 * i), 32'(4 * i + 8)};
            tests_run++;
            if ({31'd0, dec_valid, dec_pc, dec_instr, dec_pc_plus8} !== exp) begin
                tests_failed++;
                $display("FAIL stream_%0d got v=%b pc=%h instr=%h p8=%h want %h", i,
                         dec_valid, dec_pc, dec_instr, dec_pc_plus8, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if ({dec_valid, dec_pc} !== {1'b1, 32'h0}) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d got v=%b pc=%h want 1/00000000", i, dec_valid, dec_pc);
            end
        end
        tests_run++;
        if (imem_addr !== 32'h8) begin
            tests_failed++;
            $display("FAIL stall_pc got %h want 00000008", imem_addr);
        end
        dec_ready = 1'b1;
        exp_pc    = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ({dec_valid, dec_pc, dec_instr} !== {1'b1, exp_pc, BASE + exp_pc}) begin
                tests_failed++;
                $display("FAIL stall_drain_%0d got v=%b pc=%h instr=%h want pc=%h", i,
                         dec_valid, dec_pc, dec_instr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            step();
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        step();
        step();
        step();
        tests_run++;
        if (dec_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre got v=%b want 1", dec_valid);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({dec_valid, imem_addr} !== {1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL async_rst got v=%b pc=%h want 0/00000000", dec_valid, imem_addr);
        end
        step();
        rst = 1'b0;
    endtask

`ifndef FETCH_BOUND_EN
    task automatic test_redirect_full();
        do_reset(1'b0);
        step();
        step();
        step();
        tests_run++;
        if ({dec_valid, dec_pc, imem_addr} !== {1'b1, 32'h0, 32'h8}) begin
            tests_failed++;
            $display("FAIL rdf_full got v=%b pc=%h addr=%h want 1/0/8", dec_valid, dec_pc, imem_addr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        step();
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;
        tests_run++;
        if ({dec_valid, imem_addr} !== {1'b0, 32'h40}) begin
            tests_failed++;
            $display("FAIL rdf_flush got v=%b addr=%h want 0/00000040", dec_valid, imem_addr);
        end
        step();
        tests_run++;
        if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 32'h40, BASE + 32'h40}) begin
            tests_failed++;
            $display("FAIL rdf_target got v=%b pc=%h instr=%h want 1/40", dec_valid, dec_pc, dec_instr);
        end
        step();
        tests_run++;
        if ({dec_valid, dec_pc} !== {1'b1, 32'h44}) begin
            tests_failed++;
            $display("FAIL rdf_next got v=%b pc=%h want 1/00000044", dec_valid, dec_pc);
        end
    endtask

    task automatic test_redirect_pop();
        do_reset(1'b0);
        step();
        step();
        step();
        dec_ready = 1'b1;
        step();
        step();
        tests_run++;
        if ({dec_valid, dec_pc} !== {1'b1, 32'h8}) begin
            tests_failed++;
            $display("FAIL rdp_head got v=%b pc=%h want 1/00000008", dec_valid, dec_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if ({dec_valid, imem_addr} !== {1'b0, 32'h100}) begin
            tests_failed++;
            $display("FAIL rdp_flush got v=%b addr=%h want 0/00000100", dec_valid, imem_addr);
        end
        step();
        tests_run++;
        if ({dec_valid, dec_pc} !== {1'b1, 32'h100}) begin
            tests_failed++;
            $display("FAIL rdp_target got v=%b pc=%h want 1/00000100", dec_valid, dec_pc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        tests_run++;
        if ({dec_valid, imem_addr} !== {1'b0, 32'h200}) begin
            tests_failed++;
            $display("FAIL b2b_first got v=%b addr=%h want 0/00000200", dec_valid, imem_addr);
        end
        redirect_pc = 32'h0000_0303;
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if ({dec_valid, imem_addr} !== {1'b0, 32'h300}) begin
            tests_failed++;
            $display("FAIL b2b_second got v=%b addr=%h want 0/00000300", dec_valid, imem_addr);
        end
        step();
        tests_run++;
        if ({dec_valid, dec_pc} !== {1'b1, 32'h300}) begin
            tests_failed++;
            $display("FAIL b2b_target got v=%b pc=%h want 1/00000300", dec_valid, dec_pc);
        end
        step();
        tests_run++;
        if ({dec_valid, dec_pc} !== {1'b1, 32'h304}) begin
            tests_failed++;
            $display("FAIL b2b_next got v=%b pc=%h want 1/00000304", dec_valid, dec_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFD;
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_align got %h want fffffffc", imem_addr);
        end
        step();
        tests_run++;
        if ({dec_valid, dec_pc, dec_instr, dec_pc_plus8} !== {1'b1, 32'hFFFF_FFFC, 32'hE39F_FFFC, 32'h4}) begin
            tests_failed++;
            $display("FAIL wrap_top got v=%b pc=%h instr=%h p8=%h want 1/fffffffc/e39ffffc/4",
                     dec_valid, dec_pc, dec_instr, dec_pc_plus8);
        end
        step();
        tests_run++;
        if ({dec_valid, dec_pc, dec_instr} !== {1'b1, 32'h0, BASE}) begin
            tests_failed++;
            $display("FAIL wrap_zero got v=%b pc=%h instr=%h want 1/0/e3a00000", dec_valid, dec_pc, dec_instr);
        end
    endtask

    task automatic test_bound_disabled();
        do_reset(1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
        end
        tests_run++;
        if ({dec_valid, dec_pc, out_of_range} !== {1'b1, 32'h18, 1'b0}) begin
            tests_failed++;
            $display("FAIL nobound got v=%b pc=%h oor=%b want 1/00000018/0", dec_valid, dec_pc, out_of_range);
        end
    endtask
`else
    task automatic test_bound();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        tests_run++;
        if ({out_of_range, imem_addr} !== {1'b0, 32'h10}) begin
            tests_failed++;
            $display("FAIL bound_hit got oor=%b addr=%h want 0/00000010", out_of_range, imem_addr);
        end
        step();
        tests_run++;
        if ({out_of_range, imem_addr} !== {1'b1, 32'h10}) begin
            tests_failed++;
            $display("FAIL bound_set got oor=%b addr=%h want 1/00000010", out_of_range, imem_addr);
        end
        step();
        tests_run++;
        if ({dec_valid, out_of_range} !== 2'b01) begin
            tests_failed++;
            $display("FAIL bound_drain got v=%b oor=%b want 0/1", dec_valid, out_of_range);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        tests_run++;
        if ({out_of_range, imem_addr} !== {1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL bound_clear got oor=%b addr=%h want 0/00000000", out_of_range, imem_addr);
        end
        step();
        tests_run++;
        if ({dec_valid, dec_pc} !== {1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL bound_resume got v=%b pc=%h want 1/00000000", dec_valid, dec_pc);
        end
    endtask
`endif

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_async_reset();
`ifndef FETCH_BOUND_EN
        test_redirect_full();
        test_redirect_pop();
        test_back_to_back();
        test_wrap();
        test_bound_disabled();
`else
        test_bound();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that drives the word-aligned address of the combinational instruction memory and captures the returned word.
- Owns the program counter.
- Buffers fetched instructions in a 2-entry queue with their PCs, decoupling fetch from decode stalls.
- Accepts branch redirects from execute, flushing stale entries and reloading the PC.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2: queue entries; legal values 2 or 4.
- MEM_WORDS, 101: instruction memory depth in words; used only by the optional bound check.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; always equals pc.
- imem_rd  in  32  instruction word returned combinationally for imem_addr in the same cycle.
- redirect_valid  in  1  branch taken; load new PC this cycle.
- redirect_pc  in  32  branch target; bits [1:0] ignored.
- dec_valid  out  1  queue head holds a valid instruction.
- dec_ready  in  1  decode accepts the head this cycle.
- dec_instr  out  32  head instruction word.
- dec_pc  out  32  head instruction address.
- dec_pc_plus8  out  32  dec_pc+8 (architectural R15 read value).
- out_of_range  out  1  only with FETCH_BOUND_EN; tied 0 otherwise.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; queue empty (count=0, read/write pointers 0).
  - dec_valid=0, dec_instr=0, dec_pc=0, out_of_range=0.
- imem_addr = pc, combinational; pc[1:0] always 00.
- Signals:
  - pop = dec_valid & dec_ready.
  - push = ~redirect_valid & (count<DEPTH | pop) & ~stop, where stop=0 unless FETCH_BOUND_EN.
- Push: write {pc, imem_rd} at the write pointer; pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Pop: advance the read pointer.
- Simultaneous push and pop:
  - Legal when full; count is unchanged.
  - Legal when count=1; the head advances to the newly written entry.
- Count update: count <= count + push - pop.
- Pointers wrap modulo DEPTH.
- Fetch-to-decode latency is 1 cycle: an instruction pushed in cycle N is visible on dec_* in cycle N+1 at the earliest.
- Head outputs come from registered queue storage. They are stable while dec_valid & ~dec_ready.
- dec_instr/dec_pc retain their last values when dec_valid=0. Their value is don't-care for checking.
- Redirect (redirect_valid=1) has highest priority:
  - A pop in the same cycle completes; decode keeps the head it accepted.
  - All entries are then discarded: count <= 0, pointers <= 0.
  - No push occurs in the redirect cycle.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - The first target instruction is fetched in cycle N+1 and appears on dec_* in cycle N+2.
- Back-to-back redirects: the last one wins; each flushes again.
- A redirect while the queue is empty behaves identically.
- No instruction is ever duplicated or skipped outside a redirect. Pushed PCs are strictly sequential between redirects.

Optional Feature:
- Macro: FETCH_BOUND_EN.
- Defined:
  - When pc[31:2] >= MEM_WORDS, stop=1: no push, pc holds.
  - out_of_range is registered and set the cycle after stop first holds; it stays 1 until a redirect to an in-range target or reset.
  - The queue still drains normally.
- Undefined:
  - stop=0 and out_of_range=0; fetch runs freely past MEM_WORDS.
  - Memory aliasing beyond that point is the memory's concern.

Decomposition:
- Package fetch_pkg:
  - typedef word_t (logic [31:0]).
  - typedef struct packed fetch_entry_t {word_t pc; word_t instr;}.
  - Constants PC_STEP=4 and R15_OFFSET=8.
- Sub-module fetch_queue:
  - Generic DEPTH-entry FIFO of fetch_entry_t with push, pop and flush.
  - Outputs: full, empty and head.
- fetch_unit keeps the PC logic, push/pop arbitration, redirect and bound check.

Test Plan:
1. Reset release, dec_ready=1, imem returns 32'hE3A00000+pc: dec_pc shows 0,4,8,C on consecutive cycles from cycle 1; dec_instr matches; dec_pc_plus8 shows 8,C,10,14.
2. dec_ready=0 for 5 cycles after reset: the queue fills with pc 0 and 4 and pc holds at 8; dec_pc stays 0. Restoring dec_ready delivers 0,4,8 with no gap and no duplicate.
3. redirect_valid with redirect_pc=32'h0000_0042 while full: the queue empties; the next dec_valid arrives 2 cycles later with dec_pc=32'h40; old entries never appear.
4. Redirect in the same cycle as a pop of pc=8: pc=8 counts as consumed; pc=C is discarded; the target follows at N+2.
5. Async rst asserted mid-stream with no clock edge: dec_valid=0 immediately; pc=RESET_PC.
6. With FETCH_BOUND_EN and MEM_WORDS=4, pc reaches 32'h10: no further push and out_of_range=1. A redirect to 0 clears it and fetching resumes.
